// File: rtl/nios_debug_slave_sysclk_gen_pkg.sv
// Shared types, default parameters and helpers for the Nios II debug slave
// system-clock side.
package debug_slave_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam int DEF_IR_W        = 2;
  localparam int DEF_DW          = 38;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_ACT_BIT     = 34;

  // Upper bound on IR width supported by the one-hot decoder.
  localparam int MAX_IR_W = 8;
  localparam int MAX_NCMD = 256;

  // One-hot decode of an instruction code; codes at or above ncmd decode to zero.
  function automatic logic [MAX_NCMD-1:0] onehot(input logic [MAX_IR_W-1:0] ir,
                                                 input int ncmd);
    logic [MAX_NCMD-1:0] vec;
    vec = '0;
    for (int i = 0; i < MAX_NCMD; i++) begin
      if ((i < ncmd) && (ir == i[MAX_IR_W-1:0])) begin
        vec[i] = 1'b1;
      end else begin
        vec[i] = 1'b0;
      end
    end
    return vec;
  endfunction

endpackage

// File: rtl/nios_debug_slave_sysclk_gen_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level strobe followed by a
// rising-edge detector producing a one-cycle pulse in the clk domain.
module debug_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [SYNC_STAGES-1:0] settle_q;
  logic [SYNC_STAGES-1:0] settle_d;
  logic                   hist_q;
  logic                   hist_d;

  // Next-state: shift the strobe through the chain. The history flop is
  // pinned at 1 until the chain has been refilled with real samples after
  // reset, so a strobe that was already high through reset gives no edge.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], async_in};
    settle_d = {settle_q[SYNC_STAGES-2:0], 1'b1};
    if (settle_q[SYNC_STAGES-1]) begin
      hist_d = sync_q[SYNC_STAGES-1];
    end else begin
      hist_d = 1'b1;
    end
    rise = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  // Synchroniser, settle and history registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      settle_q <= '0;
      hist_q   <= 1'b1;
    end else begin
      sync_q   <= sync_d;
      settle_q <= settle_d;
      hist_q   <= hist_d;
    end
  end

endmodule

// File: rtl/nios_debug_slave_sysclk_gen.sv
// System-clock half of the Nios II JTAG debug slave: brings IR / shift
// register updates into the CPU domain and presents one-hot requests to the
// OCI logic with a ready handshake and sticky overrun flag.
module nios_debug_slave_sysclk_gen
  import debug_slave_pkg::*;
#(
  parameter int IR_W        = DEF_IR_W,
  parameter int DW          = DEF_DW,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int ACT_BIT     = DEF_ACT_BIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IR_W-1:0]     ir_in,
  input  logic [DW-1:0]       sr,
  input  logic                vs_uir,
  input  logic                vs_udr,
  input  logic                action_ready,
  input  logic                overrun_clr,
  output logic [DW-1:0]       jdo,
  output logic [IR_W-1:0]     ir_q,
  output logic [2**IR_W-1:0]  take_action,
  output logic [2**IR_W-1:0]  take_no_action,
  output logic                busy,
  output logic                overrun
);

  localparam int NCMD = 2**IR_W;

  state_e              state_q;
  state_e              state_d;
  logic [DW-1:0]       jdo_q;
  logic [DW-1:0]       jdo_d;
  logic [IR_W-1:0]     ir_d;
  logic                overrun_q;
  logic                overrun_d;
  logic                ovr_event_s;
  logic                uir_rise_s;
  logic                udr_rise_s;
  logic [MAX_IR_W-1:0] ir_ext_s;
  logic [MAX_NCMD-1:0] sel_s;

  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (vs_uir),
    .rise     (uir_rise_s)
  );

  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (vs_udr),
    .rise     (udr_rise_s)
  );

  // Next-state: capture IR/data in IDLE, wait for ready in ISSUE, flag any
  // update that lands while a request is still outstanding.
  always_comb begin
    state_d     = state_q;
    jdo_d       = jdo_q;
    ir_d        = ir_q;
    ovr_event_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (uir_rise_s) begin
          ir_d = ir_in;
        end else begin
          ir_d = ir_q;
        end
        if (udr_rise_s) begin
          jdo_d   = sr;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (action_ready) begin
          state_d = IDLE;
        end else begin
          state_d = ISSUE;
        end
        ovr_event_s = uir_rise_s | udr_rise_s;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A new overrun event takes priority over a clear in the same cycle.
    if (ovr_event_s) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Request decode from registered state, IR and data word.
  always_comb begin
    ir_ext_s             = '0;
    ir_ext_s[IR_W-1:0]   = ir_q;
    sel_s                = onehot(ir_ext_s, NCMD);
    take_action          = '0;
    take_no_action       = '0;
    busy                 = 1'b0;
    if (state_q == ISSUE) begin
      busy = 1'b1;
      if (jdo_q[ACT_BIT]) begin
        take_action = sel_s[NCMD-1:0];
      end else begin
        take_no_action = sel_s[NCMD-1:0];
      end
    end else begin
      busy = 1'b0;
    end
  end

  // State, captured words and overrun flag with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      jdo_q     <= '0;
      ir_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      jdo_q     <= jdo_d;
      ir_q      <= ir_d;
      overrun_q <= overrun_d;
    end
  end

  assign jdo     = jdo_q;
  assign overrun = overrun_q;

endmodule
